// File: rtl/colour_uart_pkg.sv
// ASCII constants, FSM encoding and hex/ASCII helpers shared by the
// colour UART transmit and receive paths.
`timescale 1ns/1ps
package colour_uart_pkg;

    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_A    = 8'h41;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) return CH_0 + {4'd0, nib};
        else             return CH_A + {4'd0, nib} - 8'd10;
    endfunction

    // Accepts both cases on receive; anything that is not a hex digit decodes to 0.
    function automatic logic [3:0] ascii_to_nibble(input logic [7:0] ch);
        if (ch >= 8'h30 && ch <= 8'h39)      return 4'(ch - CH_0);
        else if (ch >= 8'h41 && ch <= 8'h46) return 4'(ch - CH_A + 8'd10);
        else if (ch >= 8'h61 && ch <= 8'h66) return 4'(ch - 8'h61 + 8'd10);
        else                                 return 4'd0;
    endfunction

endpackage

// File: rtl/color_hex_tx.sv
// Snapshots a 24-bit colour on request and streams it to uart_tx as
// optional '#', six uppercase hex digits (MSB first) and a terminator byte.
`timescale 1ns/1ps
module color_hex_tx
    import colour_uart_pkg::*;
#(
    parameter bit         PREFIX_EN = 1'b0,
    parameter logic [7:0] TERM_CHAR = 8'h0A
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [23:0] I_color,
    input  logic        I_send,
    output logic        O_busy,
    output logic        O_done,
    output logic [7:0]  O_tx_data,
    output logic        O_tx_data_valid,
    input  logic        I_tx_data_ready
);

    localparam logic [2:0] IDX_LAST        = PREFIX_EN ? 3'd7 : 3'd6;
    localparam logic [2:0] IDX_FIRST_DIGIT = PREFIX_EN ? 3'd1 : 3'd0;

    tx_state_t   state, state_nx;
    logic [2:0]  idx, idx_nx;
    logic [23:0] snap, snap_nx;
    logic [2:0]  digit;
    logic [3:0]  nib;
    logic [7:0]  cur_byte;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= ST_IDLE;
            idx   <= 3'd0;
            snap  <= 24'd0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            snap  <= snap_nx;
        end
    end

    // Byte mux: idx walks prefix / digits / terminator; digit 0 is the top nibble.
    always_comb begin
        digit = idx - IDX_FIRST_DIGIT;
        case (digit)
            3'd0:    nib = snap[23:20];
            3'd1:    nib = snap[19:16];
            3'd2:    nib = snap[15:12];
            3'd3:    nib = snap[11:8];
            3'd4:    nib = snap[7:4];
            default: nib = snap[3:0];
        endcase
        if (PREFIX_EN && idx == 3'd0) cur_byte = CH_HASH;
        else if (idx == IDX_LAST)     cur_byte = TERM_CHAR;
        else                          cur_byte = nibble_to_ascii(nib);
    end

    // Valid comes straight from state so an async reset drops it at once;
    // the GAP cycle keeps a slow-to-deassert ready from taking a byte twice.
    always_comb begin
        state_nx        = state;
        idx_nx          = idx;
        snap_nx         = snap;
        O_busy          = (state != ST_IDLE);
        O_done          = 1'b0;
        O_tx_data       = 8'd0;
        O_tx_data_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (I_send) begin
                    snap_nx  = I_color;
                    idx_nx   = 3'd0;
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                O_tx_data_valid = 1'b1;
                O_tx_data       = cur_byte;
                if (I_tx_data_ready) state_nx = ST_GAP;
            end
            ST_GAP: begin
                if (idx == IDX_LAST) begin
                    O_done   = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    idx_nx   = idx + 3'd1;
                    state_nx = ST_SEND;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_color_hex_tx.sv
// Randomised self-checking bench for color_hex_tx: one instance without and
// one with the '#' prefix, checked against a queue-based frame model.
`timescale 1ns/1ps
module tb_color_hex_tx;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst_n;
    logic [23:0] color [2];
    logic        send  [2];
    logic        ready [2];
    logic        busy  [2];
    logic        done  [2];
    logic [7:0]  data  [2];
    logic        valid [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_cnt [2];
    int done_cyc [2];
    logic [7:0] rx0[$];
    logic [7:0] rx1[$];

    color_hex_tx #(.PREFIX_EN(1'b0), .TERM_CHAR(8'h0A)) u_dut0 (
        .I_clk(clk), .I_rst_n(rst_n), .I_color(color[0]), .I_send(send[0]),
        .O_busy(busy[0]), .O_done(done[0]), .O_tx_data(data[0]),
        .O_tx_data_valid(valid[0]), .I_tx_data_ready(ready[0])
    );

    color_hex_tx #(.PREFIX_EN(1'b1), .TERM_CHAR(8'h0A)) u_dut1 (
        .I_clk(clk), .I_rst_n(rst_n), .I_color(color[1]), .I_send(send[1]),
        .O_busy(busy[1]), .O_done(done[1]), .O_tx_data(data[1]),
        .O_tx_data_valid(valid[1]), .I_tx_data_ready(ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected frame straight from the text rules: '#'?, six hex digits, LF.
    function automatic bq_t ref_frame(input logic [23:0] col, input bit pfx);
        bq_t q;
        int  n;
        q = {};
        if (pfx) q.push_back(8'h23);
        for (int i = 5; i >= 0; i--) begin
            n = int'((col >> (4 * i)) & 24'hF);
            if (n < 10) q.push_back(8'(48 + n));
            else        q.push_back(8'(65 + n - 10));
        end
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic rx_push(input int d, input logic [7:0] b);
        if (d == 0) rx0.push_back(b);
        else        rx1.push_back(b);
    endtask

    function automatic int rx_size(input int d);
        return (d == 0) ? rx0.size() : rx1.size();
    endfunction

    function automatic logic [7:0] rx_at(input int d, input int i);
        if (i >= rx_size(d)) return 8'h00;
        return (d == 0) ? rx0[i] : rx1[i];
    endfunction

    task automatic rx_clear(input int d);
        if (d == 0) rx0.delete();
        else        rx1.delete();
        done_cnt[d] = 0;
    endtask

    // Handshake monitor: collects transferred bytes, checks hold-while-stalled
    // and the one-cycle valid drop after every transfer.
    initial begin
        logic       pv [2];
        logic       px [2];
        logic [7:0] pd [2];
        for (int d = 0; d < 2; d++) begin pv[d] = 0; px[d] = 0; pd[d] = 0; end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    pv[d] = 0;
                    px[d] = 0;
                end else begin
                    if (px[d]) check("gap_after_xfer", valid[d], 0);
                    else if (pv[d]) begin
                        check("hold_valid", valid[d], 1);
                        check("hold_data", data[d], pd[d]);
                    end
                    if (valid[d] && ready[d]) rx_push(d, data[d]);
                    if (done[d]) begin
                        done_cnt[d]++;
                        done_cyc[d] = cyc;
                    end
                    pv[d] = valid[d];
                    px[d] = valid[d] && ready[d];
                    pd[d] = data[d];
                end
            end
        end
    end

    task automatic run_frame(input int d, input logic [23:0] col, input int rdy_pct,
                             input int stall_at, input bit inject, input bit chk_timing);
        bq_t exp;
        int  start;
        bit  stalled;
        bit  injected;
        exp      = ref_frame(col, d == 1);
        stalled  = 0;
        injected = 0;
        rx_clear(d);
        color[d] = col;
        send[d]  = 1'b1;
        ready[d] = ($urandom_range(99) < rdy_pct);
        @(posedge clk); #1;
        start   = cyc;
        send[d] = 1'b0;
        @(negedge clk);
        check("first_valid", valid[d], 1);
        check("first_busy", busy[d], 1);
        check("first_data", data[d], exp[0]);
        for (int k = 0; k < 400 && done_cnt[d] == 0; k++) begin
            @(posedge clk); #1;
            send[d] = 1'b0;
            if (inject && !injected && rx_size(d) == 3) begin
                send[d]  = 1'b1;
                color[d] = 24'h000000;
                injected = 1;
            end
            if (stall_at >= 0 && !stalled && rx_size(d) == stall_at && valid[d]) begin
                ready[d] = 1'b0;
                repeat (50) begin
                    @(negedge clk);
                    check("stall_valid", valid[d], 1);
                    check("stall_data", data[d], exp[stall_at]);
                end
                @(posedge clk); #1;
                ready[d] = 1'b1;
                stalled  = 1;
            end else begin
                ready[d] = ($urandom_range(99) < rdy_pct);
            end
        end
        send[d]  = 1'b0;
        ready[d] = 1'b1;
        if (done_cnt[d] == 0) check("done_timeout", 0, 1);
        if (stall_at >= 0) check("stall_reached", 32'(stalled), 1);
        if (inject) check("inject_reached", 32'(injected), 1);
        repeat (6) @(posedge clk);
        #1;
        check("frame_len", rx_size(d), exp.size());
        for (int i = 0; i < exp.size(); i++) check("frame_byte", rx_at(d, i), exp[i]);
        check("done_count", done_cnt[d], 1);
        check("idle_busy", busy[d], 0);
        if (chk_timing) check("frame_cycles", done_cyc[d] - start, 2 * exp.size() - 1);
    endtask

    initial begin
        bq_t exp;
        bit  found;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            color[d] = 24'd0; send[d] = 1'b0; ready[d] = 1'b0;
            done_cnt[d] = 0;  done_cyc[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        send[0] = 1'b1; ready[0] = 1'b1; color[0] = 24'hFFFFFF;
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", valid[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_done", done[d], 0);
            check("rst_data", data[d], 0);
        end
        send[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready[0] = 1'b1; ready[1] = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy[0], 0);

        run_frame(0, 24'h12AB0F, 100, -1, 0, 1);
        run_frame(1, 24'hFFFFFF, 100, -1, 0, 1);
        run_frame(0, 24'h12AB0F, 100, 2, 0, 0);
        run_frame(0, 24'h5C3E91, 100, -1, 1, 1);

        // Reset in the middle of the fourth byte.
        rx_clear(0);
        color[0] = 24'h123456; ready[0] = 1'b1; send[0] = 1'b1;
        @(posedge clk); #1;
        send[0] = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (rx_size(0) == 3 && valid[0]) begin found = 1; break; end
            @(posedge clk); #1;
        end
        check("rst_reach", 32'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", valid[0], 0);
        check("midrst_busy", busy[0], 0);
        check("midrst_data", data[0], 0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_done", done[0], 0);
        end
        check("midrst_done_cnt", done_cnt[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_frame(0, 24'h00000A, 100, -1, 0, 1);

        // Send held high: back-to-back frames, one idle cycle in between.
        rx_clear(0);
        exp = ref_frame(24'hA1B2C3, 0);
        color[0] = 24'hA1B2C3; ready[0] = 1'b1; send[0] = 1'b1;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done[0]) begin found = 1; break; end
        end
        check("held_done1", 32'(found), 1);
        @(negedge clk);
        check("held_idle_valid", valid[0], 0);
        check("held_idle_busy", busy[0], 0);
        @(negedge clk);
        check("held_restart_valid", valid[0], 1);
        check("held_restart_data", data[0], exp[0]);
        @(posedge clk); #1;
        send[0] = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done[0]) begin found = 1; break; end
        end
        check("held_done2", 32'(found), 1);
        repeat (4) @(posedge clk);
        #1;
        check("held_len", rx_size(0), 2 * exp.size());
        for (int i = 0; i < 2 * exp.size(); i++)
            check("held_byte", rx_at(0, i), exp[i % exp.size()]);
        check("held_done_cnt", done_cnt[0], 2);
        check("held_end_busy", busy[0], 0);

        for (int i = 0; i < 12; i++)
            run_frame(0, 24'($urandom), $urandom_range(30, 100), -1, 0, 0);
        for (int i = 0; i < 8; i++)
            run_frame(1, 24'($urandom), $urandom_range(30, 100), -1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/color_hex_tx.md
Name: color_hex_tx

Overview:
Transmit-side companion to the UART line receiver that sets the display colour. On request, it snapshots a 24-bit colour word and sends it as uppercase ASCII hex over the uart_tx byte handshake: an optional '#', six hex digits MSB-first, then LF (0x0A). Sits in I_clk domain between the colour register logic and the uart_tx instance; used for status/echo of the active colour.

Parameters:
PREFIX_EN, 0, 1 = emit '#' (0x23) before the hex digits
TERM_CHAR, 8'h0A, terminator byte sent after the last digit

Ports:
I_clk  in  1  system clock (27 MHz)
I_rst_n  in  1  asynchronous reset, active-low
I_color  in  24  colour word to report, {B,G,R}, sampled on accepted request
I_send  in  1  request pulse/level; accepted only when idle
O_busy  out  1  high from the cycle after acceptance until the frame completes
O_done  out  1  one-cycle pulse after the terminator byte is transferred
O_tx_data  out  8  byte to uart_tx
O_tx_data_valid  out  1  byte valid to uart_tx
I_tx_data_ready  in  1  uart_tx ready to accept a byte

Behaviour:
- Reset: I_clk clocks the block; I_rst_n is asynchronous, active-low. While reset is asserted, all outputs are 0, the FSM is in IDLE, the snapshot register is 0 and the byte index is 0.
- Transfer rule: a byte transfers on a rising edge where O_tx_data_valid && I_tx_data_ready.
  - O_tx_data is stable while valid is high.
  - Valid stays high until the transfer occurs, so stalls of any length are allowed.
- After each transfer, valid drops for exactly one cycle (GAP). This avoids a double-accept while uart_tx deasserts ready.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if I_send=1, capture I_color into snap, set idx=0, go to SEND. O_busy rises next cycle.
  - SEND: valid=1 and data=byte(idx). On transfer, set valid=0 and go to GAP.
  - GAP: if idx == last, pulse O_done and go to IDLE. Otherwise idx+1 and go to SEND.
- Byte sequence, with N = 7 + PREFIX_EN bytes per frame:
  - optional '#'
  - hex(snap[23:20]), hex(snap[19:16]), and so on down to hex(snap[3:0])
  - TERM_CHAR
- Hex encoding: nibble 0-9 maps to 0x30+n; nibble 10-15 maps to 0x41+(n-10). Uppercase only.
- Latency: I_send sampled at edge k, first byte valid at edge k+1. With ready held high, each byte takes 2 cycles (SEND, GAP).
- O_busy = (state != IDLE). O_done is asserted in the same cycle the FSM returns to IDLE.
- I_send while busy (including the O_done cycle) is ignored, not queued. I_send held high restarts a new frame in the cycle after the return to IDLE.
- I_color changes during a frame have no effect, because only snap is sent.
- I_tx_data_ready high while not in SEND has no effect.
- Reset mid-frame: valid drops immediately (asynchronous), the frame is abandoned, and no O_done is generated.
- idx is a 3-bit index; its maximum is 7 (with prefix), and there is no wrap within a frame.

Decomposition:
- Shared package (colour_uart_pkg):
  - ASCII constants: CH_HASH=8'h23, CH_LF=8'h0A, CH_0=8'h30, CH_A=8'h41
  - FSM state localparams
  - function nibble_to_ascii(4-bit) -> 8-bit. The same package also holds the inverse ascii_to_nibble used by the receive path.
- No sub-module needed; the byte mux is a small case on idx using the package function.

Test Plan:
- PREFIX_EN=0, I_color=24'h12AB0F, pulse I_send, ready always 1 -> bytes 0x31,0x32,0x41,0x42,0x30,0x46,0x0A in order; O_done one cycle after the last transfer; 14 cycles total.
- PREFIX_EN=1, I_color=24'hFFFFFF -> 0x23 followed by six 0x46, then 0x0A; 8 transfers, one O_done.
- Ready held low 50 cycles during byte 3 -> valid stays 1 and data stays 0x41 throughout; the sequence resumes unchanged with no duplicated or lost byte.
- I_send pulsed again mid-frame and I_color changed to 24'h000000 -> current frame unaffected; no second frame starts.
- Assert I_rst_n=0 during byte 4 -> O_tx_data_valid=0, O_busy=0 immediately, no O_done. After release, I_send with 24'h00000A -> 0x30 x5, 0x41, 0x0A.
- I_send held high continuously -> back-to-back frames with exactly one IDLE cycle between O_done and the next valid.
